// File: rtl/at25010_pkg.sv
// Shared constants and types for the AT25010 EEPROM responder.
// Opcodes are also used by the host-side at25010_if.
package at25010_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  localparam int ST_RDY_N = 0;
  localparam int ST_WEL   = 1;
  localparam int ST_BP0   = 2;
  localparam int ST_BP1   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_STATUS,
    S_IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s = '0;
    s[ST_RDY_N] = 1'b0;
    s[ST_WEL]   = wel;
    s[ST_BP0]   = 1'b0;
    s[ST_BP1]   = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/at25010_resp_spi_pin_sync.sv
// Synchronizes the SPI pins into clk and derives sck edge strobes
// plus a cs_n falling strobe that is only honoured once the pipe has settled.
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_n_s,
  output logic cs_fall,
  output logic mosi_s
);

  logic [1:0] sck_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic       sck_d_q;
  logic       cs_d_q;
  logic [1:0] settle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q    <= 2'b00;
      cs_q     <= 2'b11;
      mosi_q   <= 2'b00;
      sck_d_q  <= 1'b0;
      cs_d_q   <= 1'b1;
      settle_q <= 2'd0;
    end else begin
      sck_q   <= {sck_q[0], sck};
      cs_q    <= {cs_q[0], cs_n};
      mosi_q  <= {mosi_q[0], mosi};
      sck_d_q <= sck_q[1];
      cs_d_q  <= cs_q[1];
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // A cs_n held low across reset must not look like a new transaction
  assign cs_fall  = (settle_q == 2'd3) & cs_d_q & ~cs_q[1];
  assign sck_rise = sck_q[1] & ~sck_d_q;
  assign sck_fall = ~sck_q[1] & sck_d_q;
  assign cs_n_s   = cs_q[1];
  assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/at25010_resp.sv
// AT25010-compatible SPI EEPROM responder, 128 x 8 array in flops.
// Oversamples the SPI pins on clk; mode 0, MSB first.
module at25010_resp
  import at25010_pkg::*;
#(
  parameter logic [7:0] ERASED_VAL = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data
);

  logic sck_rise, sck_fall, cs_n_s, cs_fall, mosi_s;

  spi_pin_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_n_s   (cs_n_s),
    .cs_fall  (cs_fall),
    .mosi_s   (mosi_s)
  );

  state_t     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [6:0] sin_q, sin_d;
  logic [7:0] sout_q, sout_d;
  logic       miso_q, miso_d;
  logic       wel_q, wel_d;
  logic [6:0] addr_q, addr_d;
  logic       wmode_q, wmode_d;
  logic       wrote_q, wrote_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] mem_q [128];
  logic       mem_we;
  logic [6:0] mem_wa;
  logic [7:0] mem_wd;

  logic [7:0] byte_in;
  logic [6:0] addr_inc;
  logic [6:0] page_inc;
  logic       last_bit;

  assign byte_in  = {sin_q, mosi_s};
  assign addr_inc = addr_q + 7'd1;
  assign page_inc = {addr_q[6:3], addr_q[2:0] + 3'd1};
  assign last_bit = (bcnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    sin_d     = sin_q;
    sout_d    = sout_q;
    miso_d    = miso_q;
    wel_d     = wel_q;
    addr_d    = addr_q;
    wmode_d   = wmode_q;
    wrote_d   = wrote_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    mem_wa    = addr_q;
    mem_wd    = byte_in;
    if (cs_n_s) begin
      state_d = S_IDLE;
      bcnt_d  = 3'd0;
      sin_d   = '0;
      miso_d  = 1'b0;
      wrote_d = 1'b0;
      if (wrote_q) wel_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            bcnt_d  = 3'd0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sin_d  = byte_in[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              unique case (1'b1)
                byte_in == OP_WREN: begin
                  wel_d   = 1'b1;
                  state_d = S_IGNORE;
                end
                byte_in == OP_WRDI: begin
                  wel_d   = 1'b0;
                  state_d = S_IGNORE;
                end
                byte_in == OP_RDSR: begin
                  sout_d  = status_byte(wel_q);
                  state_d = S_STATUS;
                end
                byte_in == OP_READ: begin
                  wmode_d = 1'b0;
                  state_d = S_ADDR;
                end
                byte_in == OP_WRITE: begin
                  wmode_d = 1'b1;
                  state_d = wel_q ? S_ADDR : S_IGNORE;
                end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sin_d  = byte_in[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              addr_d = byte_in[6:0];
              if (wmode_q) begin
                wrote_d = 1'b1;
                state_d = S_WR_DATA;
              end else begin
                sout_d  = mem_q[byte_in[6:0]];
                state_d = S_RD_DATA;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (sck_fall) begin
            miso_d = sout_q[7];
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              addr_d = addr_inc;
              sout_d = mem_q[addr_inc];
            end else begin
              sout_d = {sout_q[6:0], 1'b0};
            end
          end
        end
        S_WR_DATA: begin
          if (sck_rise) begin
            sin_d  = byte_in[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) begin
              mem_we    = 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = byte_in;
              addr_d    = page_inc;
            end
          end
        end
        S_STATUS: begin
          if (sck_fall) begin
            miso_d = sout_q[7];
            bcnt_d = bcnt_q + 3'd1;
            if (last_bit) sout_d = status_byte(wel_q);
            else sout_d = {sout_q[6:0], 1'b0};
          end
        end
        S_IGNORE: begin
          miso_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bcnt_q    <= 3'd0;
      sin_q     <= '0;
      sout_q    <= '0;
      miso_q    <= 1'b0;
      wel_q     <= 1'b0;
      addr_q    <= '0;
      wmode_q   <= 1'b0;
      wrote_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      sin_q     <= sin_d;
      sout_q    <= sout_d;
      miso_q    <= miso_d;
      wel_q     <= wel_d;
      addr_q    <= addr_d;
      wmode_q   <= wmode_d;
      wrote_q   <= wrote_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem_q[i] <= ERASED_VAL;
    end else if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign miso    = miso_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_at25010_resp.sv
// Bench for at25010_resp: bit-banged SPI master, array model, scoreboard.
// Directed scenarios followed by randomized transactions.
module tb_at25010_resp;
  import at25010_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  at25010_resp #(.ERASED_VAL(8'hFF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem_m [128];
  bit          wel_m;
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  rx_q [$];
  logic [14:0] exp_wr_q [$];
  logic [7:0]  wd [16];
  logic [14:0] mon_e;
  logic [7:0]  mon_r;

  task automatic check8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Scoreboard: compares committed writes and received read bytes
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %02h data %02h, expected none",
                 wr_addr, wr_data);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check8("wr_addr", {1'b0, wr_addr}, {1'b0, mon_e[14:8]});
        check8("wr_data", wr_data, mon_e[7:0]);
      end
    end
    if (rx_q.size() != 0) begin
      mon_r = rx_q.pop_front();
      if (exp_rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rx: got %02h expected none", mon_r);
      end else begin
        check8("rd_byte", mon_r, exp_rd_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem_m[i] = 8'hFF;
    wel_m = 1'b0;
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    tick($urandom_range(7, 5));
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, input bit cap);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7-i];
      tick($urandom_range(7, 5));
      sck = 1'b1;
      r = {r[6:0], miso};
      tick($urandom_range(7, 5));
      sck = 1'b0;
    end
    if (cap) rx_q.push_back(r);
  endtask

  task automatic spi_end();
    tick(6);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(8);
  endtask

  task automatic op_wren();
    spi_begin();
    spi_bits(OP_WREN, 8, 1'b0);
    spi_end();
    wel_m = 1'b1;
  endtask

  task automatic op_wrdi();
    spi_begin();
    spi_bits(OP_WRDI, 8, 1'b0);
    spi_end();
    wel_m = 1'b0;
  endtask

  task automatic op_rdsr(input int n);
    for (int i = 0; i < n; i++) exp_rd_q.push_back({6'b0, wel_m, 1'b0});
    spi_begin();
    spi_bits(OP_RDSR, 8, 1'b0);
    for (int i = 0; i < n; i++) spi_bits(8'h00, 8, 1'b1);
    spi_end();
  endtask

  task automatic op_read(input logic [6:0] a, input int n);
    logic [6:0] ra;
    for (int i = 0; i < n; i++) begin
      ra = 7'(a + i);
      exp_rd_q.push_back(mem_m[ra]);
    end
    spi_begin();
    spi_bits(OP_READ, 8, 1'b0);
    spi_bits({1'($urandom), a}, 8, 1'b0);
    for (int i = 0; i < n; i++) spi_bits(8'h00, 8, 1'b1);
    spi_end();
  endtask

  task automatic op_write(input logic [6:0] a, input int nfull, input int npart);
    logic [6:0] wa;
    if (wel_m) begin
      for (int i = 0; i < nfull; i++) begin
        wa = {a[6:3], 3'(a[2:0] + i)};
        exp_wr_q.push_back({wa, wd[i]});
        mem_m[wa] = wd[i];
      end
      wel_m = 1'b0;
    end
    spi_begin();
    spi_bits(OP_WRITE, 8, 1'b0);
    spi_bits({1'($urandom), a}, 8, 1'b0);
    for (int i = 0; i < nfull; i++) spi_bits(wd[i], 8, 1'b0);
    if (npart > 0) spi_bits(wd[nfull], npart, 1'b0);
    spi_end();
  endtask

  initial begin
    model_reset();
    tick(3);
    check8("rst_miso", {7'b0, miso}, 8'h00);
    check8("rst_wr_en", {7'b0, wr_en}, 8'h00);
    check8("rst_wr_addr", {1'b0, wr_addr}, 8'h00);
    check8("rst_wr_data", wr_data, 8'h00);
    rst_n = 1'b1;
    tick(5);

    op_read(7'h10, 1);

    op_wren();
    wd[0] = 8'hA5;
    op_write(7'h10, 1, 0);
    op_read(7'h10, 1);
    op_rdsr(1);

    wd[0] = 8'h5A;
    op_write(7'h20, 1, 0);
    op_read(7'h20, 1);
    op_wren();
    op_rdsr(2);
    op_wrdi();
    op_rdsr(1);

    op_wren();
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    op_write(7'h0E, 3, 0);
    op_read(7'h08, 8);

    op_wren();
    wd[0] = 8'hC3;
    op_write(7'h7F, 1, 0);
    op_wren();
    wd[0] = 8'h3C;
    op_write(7'h00, 1, 0);
    op_read(7'h7F, 2);

    op_wren();
    wd[0] = 8'h77;
    op_write(7'h30, 0, 5);
    op_read(7'h30, 1);
    op_rdsr(1);

    op_wren();
    op_write(7'h40, 0, 0);
    op_rdsr(1);

    repeat (20) begin
      case ($urandom_range(5, 0))
        0: op_wren();
        1: op_wrdi();
        2: op_rdsr($urandom_range(2, 1));
        3: op_read(7'($urandom), $urandom_range(3, 1));
        default: begin
          if ($urandom_range(3, 0) != 0) op_wren();
          for (int i = 0; i < 8; i++) wd[i] = 8'($urandom);
          op_write(7'($urandom), $urandom_range(4, 0), $urandom_range(7, 0));
        end
      endcase
    end

    // Reset in the middle of a write data byte, cs_n kept low afterwards
    op_wren();
    tick(10);
    spi_begin();
    spi_bits(OP_WRITE, 8, 1'b0);
    spi_bits(8'h30, 8, 1'b0);
    spi_bits(8'hAB, 4, 1'b0);
    rst_n = 1'b0;
    tick(3);
    model_reset();
    rst_n = 1'b1;
    spi_bits(OP_WREN, 8, 1'b0);
    spi_end();
    op_rdsr(1);
    op_read(7'h10, 1);
    op_read(7'h7F, 1);

    tick(20);
    n_chk++;
    if (exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes: got %0d outstanding expected 0", exp_wr_q.size());
    end
    n_chk++;
    if (exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", exp_rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
